// File: rtl/sm4_cir_dec_pkg.sv
// SM4 decryptor shared definitions: widths, FSM states, FK/CK constants,
// S-box, linear transforms and the single-round helpers for data and key paths.
package sm4_cir_dec_pkg;

   localparam int unsigned SM4_ROUNDS = 32;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BLOCK_W    = 128;
   localparam int unsigned CNT_W      = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      DEC    = 2'd2,
      DONE   = 2'd3
   } sm4_state_e;

   // System parameters FK0..FK3; FK[0] occupies bits [127:96]
   localparam logic [0:3][WORD_W-1:0] FK = {
      32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
   };

   // S-box, entry 0 in the leftmost byte
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   // Round constant CK_i: byte j = (4i + j) * 7 mod 256
   function automatic logic [WORD_W-1:0] get_cki(input logic [CNT_W-1:0] idx);
      logic [WORD_W-1:0] ck;
      ck = '0;
      for (int j = 0; j < 4; j++) begin
         ck = {ck[23:0], 8'((int'(idx) * 4 + j) * 7)};
      end
      return ck;
   endfunction

   // Byte-wise non-linear substitution tau
   function automatic logic [WORD_W-1:0] tau(input logic [WORD_W-1:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Data-path linear transform L
   function automatic logic [WORD_W-1:0] l_enc(input logic [WORD_W-1:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
               ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
   endfunction

   // Key-schedule linear transform L'
   function automatic logic [WORD_W-1:0] l_key(input logic [WORD_W-1:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   // One cipher round: {X0,X1,X2,X3} -> {X1,X2,X3,X4}
   function automatic logic [BLOCK_W-1:0] one_round_for_encdec(
      input logic [BLOCK_W-1:0] x,
      input logic [WORD_W-1:0]  rk
   );
      logic [WORD_W-1:0] mix;
      mix = x[95:64] ^ x[63:32] ^ x[31:0] ^ rk;
      return {x[95:0], x[127:96] ^ l_enc(tau(mix))};
   endfunction

   // One key-schedule step: round key from {K0,K1,K2,K3} and CK_i
   function automatic logic [WORD_W-1:0] one_round_for_key_exp(
      input logic [BLOCK_W-1:0] k,
      input logic [WORD_W-1:0]  ck
   );
      logic [WORD_W-1:0] mix;
      mix = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck;
      return k[127:96] ^ l_key(tau(mix));
   endfunction

endpackage

// File: rtl/sm4_cir_dec_if.sv
// Request/response bus of the SM4 decryptor; master drives requests, slave is the decryptor.
interface sm4_cir_dec_if;
   import sm4_cir_dec_pkg::*;

   logic [BLOCK_W-1:0] ciphertext_in;
   logic [BLOCK_W-1:0] key_in;
   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] result_out;
   logic               out_valid;

   modport master (
      output ciphertext_in, key_in, in_valid,
      input  in_ready, result_out, out_valid
   );

   modport slave (
      input  ciphertext_in, key_in, in_valid,
      output in_ready, result_out, out_valid
   );

endinterface

// File: rtl/sm4_cir_dec_rk_store.sv
// 32-entry round-key register file: synchronous write during key expansion,
// combinational read during decryption. Contents are not reset.
module sm4_cir_dec_rk_store
   import sm4_cir_dec_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [CNT_W-1:0]  waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [CNT_W-1:0]  raddr_i,
   output logic [WORD_W-1:0] rdata_c_o
);

   logic [WORD_W-1:0] mem_q [0:SM4_ROUNDS-1];

   // Write one round key per key-expansion cycle
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/sm4_cir_dec.sv
// Iterative SM4 block decryptor: 32 key-expansion cycles fill the round-key
// store, then 32 decrypt rounds consume it in reverse, one round per clock.
// Optional macro SM4_DEC_KEY_CACHE_EN: remember the last expanded key and skip
// key expansion when the next request reuses it.
module sm4_cir_dec
   import sm4_cir_dec_pkg::*;
#(
   parameter int unsigned ROUNDS = SM4_ROUNDS
)(
   input  logic        clk,
   input  logic        reset,
   sm4_cir_dec_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

   sm4_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [BLOCK_W-1:0] key_q, key_d;
   logic [BLOCK_W-1:0] result_q, result_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;

`ifdef SM4_DEC_KEY_CACHE_EN
   logic [BLOCK_W-1:0] last_key_q, last_key_d;
   logic               cache_vld_q, cache_vld_d;
`endif

   logic [WORD_W-1:0]  rk_new_c;
   logic [WORD_W-1:0]  rk_rd_c;
   logic [BLOCK_W-1:0] dec_next_c;
   logic               rk_we_c;
   logic [CNT_W-1:0]   rk_raddr_c;

   // Round-key store: written at index cnt, read back at 31-cnt
   assign rk_we_c    = (state_q == KEYEXP);
   assign rk_raddr_c = LAST_RND - cnt_q;

   sm4_cir_dec_rk_store u_rk_store (
      .clk       (clk),
      .we_i      (rk_we_c),
      .waddr_i   (cnt_q),
      .wdata_i   (rk_new_c),
      .raddr_i   (rk_raddr_c),
      .rdata_c_o (rk_rd_c)
   );

   // Round datapaths for key expansion and decryption
   assign rk_new_c   = one_round_for_key_exp(key_q, get_cki(cnt_q));
   assign dec_next_c = one_round_for_encdec(data_q, rk_rd_c);

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      key_d       = key_q;
      result_d    = result_q;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b0;
`ifdef SM4_DEC_KEY_CACHE_EN
      last_key_d  = last_key_q;
      cache_vld_d = cache_vld_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               data_d = bus.ciphertext_in;
               key_d  = bus.key_in ^ FK;
               cnt_d  = '0;
`ifdef SM4_DEC_KEY_CACHE_EN
               if (cache_vld_q && (bus.key_in == last_key_q)) begin
                  state_d = DEC;
               end else begin
                  state_d     = KEYEXP;
                  last_key_d  = bus.key_in;
                  cache_vld_d = 1'b0;
               end
`else
               state_d = KEYEXP;
`endif
            end
         end
         KEYEXP: begin
            key_d = {key_q[95:0], rk_new_c};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_RND) begin
               state_d = DEC;
`ifdef SM4_DEC_KEY_CACHE_EN
               cache_vld_d = 1'b1;
`endif
            end
         end
         DEC: begin
            data_d = dec_next_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_RND) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Data register holds {X32,X33,X34,X35}; output is word-reversed
            result_d    = {data_q[31:0], data_q[63:32], data_q[95:64], data_q[127:96]};
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         key_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         key_q       <= key_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef SM4_DEC_KEY_CACHE_EN
   // Key cache; reset invalidates it, including mid key expansion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_key_q  <= '0;
         cache_vld_q <= 1'b0;
      end else begin
         last_key_q  <= last_key_d;
         cache_vld_q <= cache_vld_d;
      end
   end
`endif

   // The store depth and counter wrap only support the standard round count
   always_ff @(posedge clk) begin
      assert (ROUNDS == SM4_ROUNDS)
         else $error("sm4_cir_dec: ROUNDS must be %0d", SM4_ROUNDS);
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.result_out = result_q;

endmodule

// File: tb/tb_sm4_cir_dec.sv
// Bench for sm4_cir_dec: array-based SM4 reference model with a per-cycle
// compare process, plus directed requests with literal latency/result checks.
// Honours SM4_DEC_KEY_CACHE_EN for the expected cache-hit latency.
module tb_sm4_cir_dec;

   localparam logic [127:0] MK1 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] PT1 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT1 = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [127:0] MK2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT2 = 128'hfedcba98765432100123456789abcdef;
   localparam int FULL_LAT = 65;
`ifdef SM4_DEC_KEY_CACHE_EN
   localparam bit CACHE   = 1'b1;
   localparam int HIT_LAT = 33;
`else
   localparam bit CACHE   = 1'b0;
   localparam int HIT_LAT = 65;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_pass   = 0;
   int   n_checks = 0;

   sm4_cir_dec_if bus ();

   sm4_cir_dec #(.ROUNDS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [0:255][7:0] tb_sbox = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };
   logic [31:0] fk_tb [0:3] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

   function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   function automatic logic [31:0] sub32(input logic [31:0] v);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = tb_sbox[v[8*b +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] t_enc(input logic [31:0] v);
      logic [31:0] s;
      s = sub32(v);
      return s ^ rotl(s, 2) ^ rotl(s, 10) ^ rotl(s, 18) ^ rotl(s, 24);
   endfunction

   function automatic logic [31:0] t_key(input logic [31:0] v);
      logic [31:0] s;
      s = sub32(v);
      return s ^ rotl(s, 13) ^ rotl(s, 23);
   endfunction

   function automatic logic [31:0] ck_word(input int i);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) r = {r[23:0], 8'(((4 * i + j) * 7) % 256)};
      return r;
   endfunction

   // Full SM4 on arrays: expand all round keys, then 32 rounds (reversed keys for decrypt)
   function automatic logic [127:0] sm4_crypt(input logic [127:0] mk, input logic [127:0] blk,
                                              input bit dec);
      logic [31:0] k  [0:35];
      logic [31:0] rk [0:31];
      logic [31:0] x  [0:35];
      for (int i = 0; i < 4; i++) begin
         k[i] = mk[127 - 32*i -: 32] ^ fk_tb[i];
         x[i] = blk[127 - 32*i -: 32];
      end
      for (int i = 0; i < 32; i++) begin
         k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
         rk[i]  = k[i+4];
      end
      for (int i = 0; i < 32; i++)
         x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
      return {x[35], x[34], x[33], x[32]};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
   endtask

   // Reference model of the request/response behaviour, compared every cycle
   int           cyc       = 0;
   bit           m_ready   = 1'b1;
   bit           m_pend    = 1'b0;
   int           m_due     = 0;
   logic [127:0] m_pend_res = '0;
   logic [127:0] m_res     = '0;
   bit           m_cvld    = 1'b0;
   logic [127:0] m_lkey    = '0;
   bit           m_hit;
   bit           exp_ov;

   always @(posedge clk) begin
      cyc++;
      exp_ov = 1'b0;
      if (reset) begin
         m_ready = 1'b1;
         m_pend  = 1'b0;
         m_res   = '0;
         m_cvld  = 1'b0;
      end else if (m_pend && cyc == m_due) begin
         exp_ov  = 1'b1;
         m_res   = m_pend_res;
         m_pend  = 1'b0;
         m_ready = 1'b1;
      end else if (m_ready && bus.in_valid) begin
         m_hit      = CACHE && m_cvld && (bus.key_in == m_lkey);
         m_due      = cyc + (m_hit ? 33 : 65);
         m_pend_res = sm4_crypt(bus.key_in, bus.ciphertext_in, 1'b1);
         m_pend     = 1'b1;
         m_ready    = 1'b0;
         if (!m_hit) begin
            m_lkey = bus.key_in;
            m_cvld = 1'b1;
         end
      end
      #1;
      chk("cycle_out_valid", 128'(bus.out_valid), 128'(exp_ov));
      chk("cycle_in_ready",  128'(bus.in_ready),  128'(m_ready));
      chk("cycle_result",    bus.result_out,      m_res);
   end

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic watch_quiet(input int cycles, input string name);
      int pulses;
      pulses = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (bus.out_valid) pulses++;
      end
      chk(name, 128'(pulses), 128'd0);
   endtask

   // One request; optional busy-time pulse of a second request, optional reset abort
   task automatic run_req(input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] exp_res, input int exp_lat,
                          input int pulse_at, input int reset_at, input string name);
      int n;
      bit seen;
      @(negedge clk);
      bus.ciphertext_in = ct;
      bus.key_in        = key;
      bus.in_valid      = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         if (pulse_at > 0 && n == pulse_at - 1) begin
            bus.in_valid      = 1'b1;
            bus.ciphertext_in = ~ct;
         end
         if (pulse_at > 0 && n == pulse_at) bus.in_valid = 1'b0;
         if (reset_at > 0 && n == reset_at) begin
            pulse_reset();
            @(posedge clk); #1;
            chk({name, "_ready_after_reset"}, 128'(bus.in_ready), 128'd1);
            watch_quiet(80, {name, "_no_out_valid"});
            return;
         end
         @(posedge clk); #1;
         n++;
         if (n == 10) chk({name, "_busy_in_ready"}, 128'(bus.in_ready), 128'd0);
         if (bus.out_valid) seen = 1'b1;
      end
      if (!seen) $display("FAIL %s_timeout: no out_valid within 200 cycles", name);
      chk({name, "_latency"}, 128'(n), 128'(exp_lat));
      chk({name, "_result"}, bus.result_out, exp_res);
      chk({name, "_ready_at_done"}, 128'(bus.in_ready), 128'd1);
      @(posedge clk); #1;
      chk({name, "_pulse_width"}, 128'(bus.out_valid), 128'd0);
      if (pulse_at > 0) watch_quiet(70, {name, "_single_out_valid"});
   endtask

   logic [127:0] ct2, rmk, rpt, rct;

   initial begin
      bus.ciphertext_in = '0;
      bus.key_in        = '0;
      bus.in_valid      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      chk("pin_enc_vec1", sm4_crypt(MK1, PT1, 1'b0), CT1);
      chk("pin_dec_vec1", sm4_crypt(MK1, CT1, 1'b1), PT1);
      chk("pin_ck0",  128'(ck_word(0)),  128'h00070e15);
      chk("pin_ck31", 128'(ck_word(31)), 128'h646b7279);

      run_req(CT1, MK1, PT1, FULL_LAT, 0, 0, "vec1");
      run_req(CT1, MK1, PT1, HIT_LAT,  0, 0, "vec1_repeat");
      ct2 = sm4_crypt(MK2, PT2, 1'b0);
      run_req(ct2, MK2, PT2, FULL_LAT, 0, 0, "new_key");
      pulse_reset();
      run_req(ct2, MK2, PT2, FULL_LAT, 0, 0, "after_reset");

      run_req(CT1, MK1, PT1, FULL_LAT, 10, 0, "busy_request");

      pulse_reset();
      run_req(CT1, MK1, PT1, FULL_LAT, 0, 40, "abort");
      run_req(CT1, MK1, PT1, FULL_LAT, 0, 0, "after_abort");

      // Reset and request in the same cycle: the request is dropped
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.key_in   = MK1;
      bus.ciphertext_in = CT1;
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("reset_wins_ready", 128'(bus.in_ready), 128'd1);
      watch_quiet(70, "reset_wins_no_out_valid");

      for (int i = 0; i < 200; i++) begin
         rmk = {$urandom, $urandom, $urandom, $urandom};
         rpt = {$urandom, $urandom, $urandom, $urandom};
         rct = sm4_crypt(rmk, rpt, 1'b0);
         run_req(rct, rmk, rpt, FULL_LAT, 0, 0, "round_trip");
      end

      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d passed)", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
